// File: rtl/alu_pipeline_hs.sv
// Elastic three-stage ALU pipeline with valid/ready handshake: res = (op1 OPA op2) OPB op1.
// Optional registered zero/negative flags are enabled by defining ALU_PIPE_FLAGS_EN.

module alu #(
  parameter int DWIDTH = 8
) (
  input  logic [1:0]        sel_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic [DWIDTH-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (sel_i)
      2'b00:   y_o = a_i + b_i;
      2'b01:   y_o = a_i - b_i;
      2'b10:   y_o = a_i & b_i;
      default: y_o = a_i | b_i;
    endcase
  end
endmodule

module reg_rst #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (rst)       q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

module alu_pipeline_hs #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  logic [1:0]        sela_i,
  input  logic [1:0]        selb_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              zero_o,
  output logic              neg_o
);
  logic [2:0] v;
  logic [2:0] v_next;
  logic [2:0] rdy;

  logic [DWIDTH-1:0] s1_op1, s1_op2, s2_op1, s2_ra;
  logic [1:0]        s1_sela, s1_selb, s2_selb;
  logic [DWIDTH-1:0] ra, rb;

  // A stage is free when empty or when its downstream moves this cycle.
  assign rdy[2] = ~v[2] | out_ready_i;
  assign rdy[1] = ~v[1] | rdy[2];
  assign rdy[0] = ~v[0] | rdy[1];

  assign v_next      = {v[1], v[0], in_valid_i};
  assign in_ready_o  = rdy[0];
  assign out_valid_o = v[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_valid
      reg_rst #(.WIDTH(1)) u_v (
        .clk  (clk),
        .rst  (rst),
        .en_i (rdy[gi]),
        .d_i  (v_next[gi]),
        .q_o  (v[gi])
      );
    end
  endgenerate

  reg_rst #(.WIDTH(2*DWIDTH+4)) u_s1 (
    .clk  (clk),
    .rst  (rst),
    .en_i (rdy[0]),
    .d_i  ({op1_i, op2_i, sela_i, selb_i}),
    .q_o  ({s1_op1, s1_op2, s1_sela, s1_selb})
  );

  alu #(.DWIDTH(DWIDTH)) u_alu_a (
    .sel_i (s1_sela),
    .a_i   (s1_op1),
    .b_i   (s1_op2),
    .y_o   (ra)
  );

  reg_rst #(.WIDTH(2*DWIDTH+2)) u_s2 (
    .clk  (clk),
    .rst  (rst),
    .en_i (rdy[1]),
    .d_i  ({ra, s1_op1, s1_selb}),
    .q_o  ({s2_ra, s2_op1, s2_selb})
  );

  alu #(.DWIDTH(DWIDTH)) u_alu_b (
    .sel_i (s2_selb),
    .a_i   (s2_ra),
    .b_i   (s2_op1),
    .y_o   (rb)
  );

  reg_rst #(.WIDTH(DWIDTH)) u_s3 (
    .clk  (clk),
    .rst  (rst),
    .en_i (rdy[2]),
    .d_i  (rb),
    .q_o  (res_o)
  );

`ifdef ALU_PIPE_FLAGS_EN
  reg_rst #(.WIDTH(2)) u_flags (
    .clk  (clk),
    .rst  (rst),
    .en_i (rdy[2]),
    .d_i  ({rb == '0, rb[DWIDTH-1]}),
    .q_o  ({zero_o, neg_o})
  );
`else
  assign zero_o = 1'b0;
  assign neg_o  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipeline_hs.sv
// Self-checking bench for alu_pipeline_hs: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.

module tb_alu_pipeline_hs;
  localparam int DW = 8;
`ifdef ALU_PIPE_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] op1 = '0, op2 = '0;
  logic [1:0]    sela = '0, selb = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] res;
  logic          zero, neg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_res   = '0;
  logic          prev_zero  = 1'b0, prev_neg = 1'b0;

  always #5 clk = ~clk;

  alu_pipeline_hs #(.DWIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op1_i       (op1),
    .op2_i       (op2),
    .sela_i      (sela),
    .selb_i      (selb),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .zero_o      (zero),
    .neg_o       (neg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [DW-1:0] apply_op(input logic [1:0] s, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [DW-1:0] model(input logic [1:0] sa, input logic [1:0] sb,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    return apply_op(sb, apply_op(sa, a, b), a);
  endfunction

  // Scoreboard: inputs change only just after rising edges, so the negative edge
  // sees exactly the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_res", res, prev_res);
        check("hold_flags", {zero, neg}, {prev_zero, prev_neg});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("sb_res", res, e);
          check("sb_flags", {zero, neg}, FLAGS_EN ? {e == '0, e[DW-1]} : 2'b00);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sela, selb, op1, op2));
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
      prev_zero  = zero;
      prev_neg   = neg;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    sela;
    logic [1:0]    selb;
    logic [DW-1:0] res;
    logic          zero;
    logic          neg;
  } vec_t;

  // One isolated transaction: checks acceptance, 3-edge latency and the result.
  task automatic run_single(input vec_t t, input string tag);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; op1 = t.op1; op2 = t.op2; sela = t.sela; selb = t.selb;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_res"}, res, t.res);
    check({tag, "_zero"}, zero, FLAGS_EN ? t.zero : 1'b0);
    check({tag, "_neg"}, neg, FLAGS_EN ? t.neg : 1'b0);
    step();
  endtask

  task automatic drain(input string tag);
    int cyc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 50) begin
      step();
      cyc++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 2'd0, 2'd1, 8'h03, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 8'h20, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 8'h01, 2'd1, 2'd1, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h0F, 8'h3C, 2'd2, 2'd3, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h00, 2'd3, 2'd2, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 2'd3, 2'd1, 8'h55, 1'b0, 1'b0};

    // Reset held two cycles with a transaction offered.
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; op1 = 8'h11; op2 = 8'h22; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_zero", zero, 0);
    check("rst_neg", neg, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_nothing_emerges", out_valid, 0);
    end

    for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: fill three stages, then release with a fourth waiting.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; op1 = DW'(i); op2 = DW'(i); sela = 2'd0; selb = 2'd1;
      check("bp_accept_ready", in_ready, 1);
      step();
    end
    op1 = 8'd4; op2 = 8'd4;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_out_valid", out_valid, 1);
    check("bp_full_res", res, 8'd1);
    step();
    step();
    check("bp_still_full", in_ready, 0);
    check("bp_held_res", res, 8'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int n = 2; n <= 4; n++) begin
      check("bp_seq_valid", out_valid, 1);
      check("bp_seq_res", res, DW'(n));
      step();
    end
    check("bp_empty", out_valid, 0);

    // Reset while two transactions are in flight.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op1 = 8'h40 + DW'(i); op2 = 8'h01; sela = 2'd0; selb = 2'd0;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_output", out_valid, 0);
      step();
    end
    run_single('{8'h09, 8'h04, 2'd1, 2'd0, 8'h0E, 1'b0, 1'b0}, "post_rst");

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op1  = DW'($urandom);
      op2  = DW'($urandom);
      sela = 2'($urandom);
      selb = 2'($urandom);
      step();
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
